// File: rtl/ic_axi_sram_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to single-port SRAM bridge:
// AXI response codes and the bridge FSM state encoding.
package ic_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RRSP = 2'd2,
    ST_WRSP = 2'd3
  } state_e;

  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/ic_axi_skid_buf.sv
// One-entry valid/ready holding buffer: ready while empty, loads on
// handshake, empties when the consumer pops it.
module ic_axi_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             pop_i
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ic_axi_sram_bridge.sv
// AXI4-Lite slave bridging to a single-port SRAM with one-cycle read latency.
// Optional IC_AXI_SRAM_RANGE_CHECK_EN: out-of-window accesses return SLVERR.
module ic_axi_sram_bridge
  import ic_pkg::*;
#(
  parameter int          SRAM_DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0
) (
  input  logic                       s0_aclk,
  input  logic                       s0_aresetn,
  input  logic                       s0_awvalid,
  output logic                       s0_awready,
  input  logic [31:0]                s0_awaddr,
  input  logic [2:0]                 s0_awprot,
  input  logic                       s0_wvalid,
  output logic                       s0_wready,
  input  logic [31:0]                s0_wdata,
  input  logic [3:0]                 s0_wstrb,
  output logic                       s0_bvalid,
  input  logic                       s0_bready,
  output logic [1:0]                 s0_bresp,
  input  logic                       s0_arvalid,
  output logic                       s0_arready,
  input  logic [31:0]                s0_araddr,
  input  logic [2:0]                 s0_arprot,
  output logic                       s0_rvalid,
  input  logic                       s0_rready,
  output logic [1:0]                 s0_rresp,
  output logic [31:0]                s0_rdata,
  output logic                       sram_cen,
  output logic                       sram_wen,
  output logic [SRAM_DEPTH_LOG2-1:0] sram_addr,
  output logic [31:0]                sram_wdata,
  output logic [3:0]                 sram_wstrb,
  input  logic [31:0]                sram_rdata
);

  logic        aw_full, w_full, ar_full;
  logic        aw_pop, w_pop, ar_pop;
  logic [31:0] aw_addr_b, ar_addr_b;
  logic [35:0] w_b;
  logic [31:0] aw_off, ar_off;
  logic        aw_ok, ar_ok;
  logic        wr_elig, rd_elig, pick_rd;
  logic        unused_bits;

  state_e      state_q, state_d;
  logic        wr_last_q, wr_last_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;

  ic_axi_skid_buf #(.WIDTH(32)) u_aw_buf (
    .clk(s0_aclk), .rst_n(s0_aresetn), .valid_i(s0_awvalid), .ready_o(s0_awready),
    .data_i(s0_awaddr), .full_o(aw_full), .data_o(aw_addr_b), .pop_i(aw_pop)
  );

  ic_axi_skid_buf #(.WIDTH(36)) u_w_buf (
    .clk(s0_aclk), .rst_n(s0_aresetn), .valid_i(s0_wvalid), .ready_o(s0_wready),
    .data_i({s0_wstrb, s0_wdata}), .full_o(w_full), .data_o(w_b), .pop_i(w_pop)
  );

  ic_axi_skid_buf #(.WIDTH(32)) u_ar_buf (
    .clk(s0_aclk), .rst_n(s0_aresetn), .valid_i(s0_arvalid), .ready_o(s0_arready),
    .data_i(s0_araddr), .full_o(ar_full), .data_o(ar_addr_b), .pop_i(ar_pop)
  );

  assign aw_off = addr_offset(aw_addr_b, BASE_ADDR);
  assign ar_off = addr_offset(ar_addr_b, BASE_ADDR);

`ifdef IC_AXI_SRAM_RANGE_CHECK_EN
  assign aw_ok = (aw_off[31:SRAM_DEPTH_LOG2+2] == '0);
  assign ar_ok = (ar_off[31:SRAM_DEPTH_LOG2+2] == '0);
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
`endif

  // Protection bits, byte lane and (without range checking) upper offset bits carry no meaning here.
  assign unused_bits = ^{s0_awprot, s0_arprot, aw_off[31:SRAM_DEPTH_LOG2+2], aw_off[1:0],
                         ar_off[31:SRAM_DEPTH_LOG2+2], ar_off[1:0]};

  assign wr_elig = aw_full && w_full;
  assign rd_elig = ar_full;
  assign pick_rd = rd_elig && (!wr_elig || wr_last_q);

  always_comb begin
    state_d    = state_q;
    wr_last_d  = wr_last_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    bresp_d    = bresp_q;
    aw_pop     = 1'b0;
    w_pop      = 1'b0;
    ar_pop     = 1'b0;
    sram_cen   = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = ar_off[SRAM_DEPTH_LOG2+1:2];
    sram_wdata = w_b[31:0];
    sram_wstrb = w_b[35:32];
    case (state_q)
      ST_IDLE: begin
        if (pick_rd) begin
          ar_pop    = 1'b1;
          wr_last_d = 1'b0;
          if (ar_ok) begin
            sram_cen = 1'b1;
            state_d  = ST_RD;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
            state_d = ST_RRSP;
          end
        end else if (wr_elig) begin
          aw_pop    = 1'b1;
          w_pop     = 1'b1;
          wr_last_d = 1'b1;
          sram_addr = aw_off[SRAM_DEPTH_LOG2+1:2];
          state_d   = ST_WRSP;
          if (aw_ok) begin
            sram_cen = 1'b1;
            sram_wen = 1'b1;
            bresp_d  = RESP_OKAY;
          end else begin
            bresp_d  = RESP_SLVERR;
          end
        end
      end
      ST_RD: begin
        rdata_d = sram_rdata;
        rresp_d = RESP_OKAY;
        state_d = ST_RRSP;
      end
      ST_RRSP: if (s0_rready) state_d = ST_IDLE;
      ST_WRSP: if (s0_bready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // wr_last resets high so the very first contended slot goes to the read.
  always_ff @(posedge s0_aclk or negedge s0_aresetn) begin
    if (!s0_aresetn) begin
      state_q   <= ST_IDLE;
      wr_last_q <= 1'b1;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      wr_last_q <= wr_last_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end

  assign s0_rvalid = (state_q == ST_RRSP);
  assign s0_bvalid = (state_q == ST_WRSP);
  assign s0_rdata  = rdata_q;
  assign s0_rresp  = rresp_q;
  assign s0_bresp  = bresp_q;

endmodule

// File: tb/tb_ic_axi_sram_bridge.sv
// Directed self-checking bench for ic_axi_sram_bridge with a behavioural SRAM.
module tb_ic_axi_sram_bridge;

  logic        clk = 1'b0;
  logic        s0_aresetn = 1'b0;
  logic        s0_awvalid = 1'b0, s0_awready;
  logic [31:0] s0_awaddr = '0;
  logic [2:0]  s0_awprot = '0;
  logic        s0_wvalid = 1'b0, s0_wready;
  logic [31:0] s0_wdata = '0;
  logic [3:0]  s0_wstrb = '0;
  logic        s0_bvalid, s0_bready = 1'b0;
  logic [1:0]  s0_bresp;
  logic        s0_arvalid = 1'b0, s0_arready;
  logic [31:0] s0_araddr = '0;
  logic [2:0]  s0_arprot = '0;
  logic        s0_rvalid, s0_rready = 1'b0;
  logic [1:0]  s0_rresp;
  logic [31:0] s0_rdata;
  logic        sram_cen, sram_wen;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  bit          q_wen[$];
  logic [9:0]  q_addr[$];
  logic [31:0] mem [0:1023];

  ic_axi_sram_bridge #(.SRAM_DEPTH_LOG2(10), .BASE_ADDR(32'h0)) dut (
    .s0_aclk(clk), .s0_aresetn(s0_aresetn),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arprot(s0_arprot),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rresp(s0_rresp), .s0_rdata(s0_rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-strobed write, registered read, plus strobe log.
  always @(posedge clk) begin
    if (s0_aresetn && sram_cen) begin
      n_strobe++;
      q_wen.push_back(sram_wen);
      q_addr.push_back(sram_addr);
      if (sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (sram_wstrb[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
    s0_awvalid = 1'b1; s0_awaddr = addr;
    s0_wvalid  = 1'b1; s0_wdata  = data; s0_wstrb = strb;
    s0_bready  = 1'b1;
    tick();
    s0_awvalid = 1'b0; s0_wvalid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!s0_bvalid && lat < 20) begin
      tick(); lat++;
      @(negedge clk);
    end
    if (!s0_bvalid) check_val("wr_timeout", 32'(s0_bvalid), 32'd1);
    resp = s0_bresp;
    $display("WR addr=%h data=%h strb=%h resp=%0d lat=%0d", addr, data, strb, resp, lat);
    tick();
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    s0_arvalid = 1'b1; s0_araddr = addr; s0_rready = 1'b1;
    tick();
    s0_arvalid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!s0_rvalid && lat < 20) begin
      tick(); lat++;
      @(negedge clk);
    end
    if (!s0_rvalid) check_val("rd_timeout", 32'(s0_rvalid), 32'd1);
    data = s0_rdata;
    resp = s0_rresp;
    $display("RD addr=%h data=%h resp=%0d lat=%0d", addr, data, resp, lat);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          s0;

    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check_val("rst_awready", 32'(s0_awready), 32'd1);
    check_val("rst_wready", 32'(s0_wready), 32'd1);
    check_val("rst_arready", 32'(s0_arready), 32'd1);
    check_val("rst_bvalid", 32'(s0_bvalid), 32'd0);
    check_val("rst_rvalid", 32'(s0_rvalid), 32'd0);
    check_val("rst_cen", 32'(sram_cen), 32'd0);
    check_val("rst_rdata", s0_rdata, 32'd0);
    tick();
    s0_aresetn = 1'b1;
    tick();

    // Single write: AW and W together
    s0_awvalid = 1'b1; s0_awaddr = 32'h10;
    s0_wvalid = 1'b1; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF; s0_bready = 1'b1;
    tick();
    s0_awvalid = 1'b0; s0_wvalid = 1'b0;
    @(negedge clk);
    check_val("w1_c1_cen", 32'(sram_cen), 32'd1);
    check_val("w1_c1_wen", 32'(sram_wen), 32'd1);
    check_val("w1_c1_addr", 32'(sram_addr), 32'd4);
    check_val("w1_c1_wdata", sram_wdata, 32'hDEADBEEF);
    check_val("w1_c1_bvalid", 32'(s0_bvalid), 32'd0);
    tick();
    @(negedge clk);
    check_val("w1_c2_bvalid", 32'(s0_bvalid), 32'd1);
    check_val("w1_c2_bresp", 32'(s0_bresp), 32'd0);
    check_val("w1_c2_cen", 32'(sram_cen), 32'd0);
    tick();
    @(negedge clk);
    check_val("w1_c3_bvalid", 32'(s0_bvalid), 32'd0);
    $display("WR addr=00000010 data=deadbeef (same-cycle AW/W)");

    // W one cycle ahead of AW
    s0 = n_strobe;
    tick();
    s0_wvalid = 1'b1; s0_wdata = 32'hCAFEF00D; s0_wstrb = 4'hF;
    @(negedge clk);
    check_val("w2_wready_c0", 32'(s0_wready), 32'd1);
    tick();
    s0_wvalid = 1'b0; s0_awvalid = 1'b1; s0_awaddr = 32'h20;
    @(negedge clk);
    check_val("w2_wready_held", 32'(s0_wready), 32'd0);
    check_val("w2_no_early_cen", 32'(sram_cen), 32'd0);
    tick();
    s0_awvalid = 1'b0;
    @(negedge clk);
    check_val("w2_wready_issue", 32'(s0_wready), 32'd0);
    check_val("w2_cen", 32'(sram_cen), 32'd1);
    check_val("w2_addr", 32'(sram_addr), 32'd8);
    check_val("w2_wdata", sram_wdata, 32'hCAFEF00D);
    tick();
    @(negedge clk);
    check_val("w2_bvalid", 32'(s0_bvalid), 32'd1);
    check_val("w2_wready_free", 32'(s0_wready), 32'd1);
    tick(); tick();
    check_val("w2_once", 32'(n_strobe - s0), 32'd1);
    $display("WR addr=00000020 data=cafef00d (W before AW)");

    // Read back with rready low for 5 cycles
    s0_arvalid = 1'b1; s0_araddr = 32'h10; s0_rready = 1'b0;
    tick();
    s0_arvalid = 1'b0;
    @(negedge clk);
    check_val("r1_cen", 32'(sram_cen), 32'd1);
    check_val("r1_wen", 32'(sram_wen), 32'd0);
    check_val("r1_addr", 32'(sram_addr), 32'd4);
    tick();
    @(negedge clk);
    check_val("r1_c2_rvalid", 32'(s0_rvalid), 32'd0);
    tick();
    @(negedge clk);
    check_val("r1_c3_rvalid", 32'(s0_rvalid), 32'd1);
    check_val("r1_c3_rdata", s0_rdata, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      check_val("r1_hold_rvalid", 32'(s0_rvalid), 32'd1);
      check_val("r1_hold_rdata", s0_rdata, 32'hDEADBEEF);
      check_val("r1_hold_rresp", 32'(s0_rresp), 32'd0);
    end
    tick();
    s0_rready = 1'b1;
    tick();
    @(negedge clk);
    check_val("r1_done", 32'(s0_rvalid), 32'd0);
    $display("RD addr=00000010 data=deadbeef (rready stalled)");

    // Partial strobe write then read-back at full speed
    axi_write(32'h10, 32'h11112222, 4'b0011, r, lat);
    check_val("w3_resp", 32'(r), 32'd0);
    check_val("w3_lat", 32'(lat), 32'd2);
    axi_read(32'h10, d, r, lat);
    check_val("r2_data", d, 32'hDEAD2222);
    check_val("r2_resp", 32'(r), 32'd0);
    check_val("r2_lat", 32'(lat), 32'd3);

    // Out-of-window address
    axi_write(32'h0, 32'h12345678, 4'hF, r, lat);
    check_val("w4_resp", 32'(r), 32'd0);
    s0 = n_strobe;
    axi_read(32'h1000, d, r, lat);
`ifdef IC_AXI_SRAM_RANGE_CHECK_EN
    check_val("oob_rd_strobes", 32'(n_strobe - s0), 32'd0);
    check_val("oob_rd_data", d, 32'd0);
    check_val("oob_rd_resp", 32'(r), 32'd2);
    s0 = n_strobe;
    axi_write(32'h1000, 32'h55555555, 4'hF, r, lat);
    check_val("oob_wr_strobes", 32'(n_strobe - s0), 32'd0);
    check_val("oob_wr_resp", 32'(r), 32'd2);
`else
    check_val("alias_rd_strobes", 32'(n_strobe - s0), 32'd1);
    check_val("alias_rd_data", d, 32'h12345678);
    check_val("alias_rd_resp", 32'(r), 32'd0);
`endif

    // Arbitration from reset: read first, then strict alternation
    s0_aresetn = 1'b0;
    tick(); tick();
    q_wen.delete(); q_addr.delete();
    s0_aresetn = 1'b1;
    s0_arvalid = 1'b1; s0_araddr = 32'h10;
    s0_awvalid = 1'b1; s0_awaddr = 32'h40;
    s0_wvalid = 1'b1; s0_wdata = 32'hA5A5A5A5; s0_wstrb = 4'hF;
    s0_rready = 1'b1; s0_bready = 1'b1;
    for (int k = 0; k < 200 && q_wen.size() < 8; k++) tick();
    s0_arvalid = 1'b0; s0_awvalid = 1'b0; s0_wvalid = 1'b0;
    check_val("arb_count", 32'(q_wen.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < q_wen.size(); k++) begin
      check_val("arb_order", 32'(q_wen[k]), 32'(k % 2));
      check_val("arb_addr", 32'(q_addr[k]), (k % 2) ? 32'd16 : 32'd4);
      $display("ARB slot=%0d wen=%0d addr=%0d", k, q_wen[k], q_addr[k]);
    end
    for (int k = 0; k < 30; k++) tick();

    // Reset while a read response is held
    s0_arvalid = 1'b1; s0_araddr = 32'h20; s0_rready = 1'b0;
    tick();
    s0_arvalid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!s0_rvalid && lat < 20) begin
      tick(); lat++;
      @(negedge clk);
    end
    check_val("rst_mid_rvalid_pre", 32'(s0_rvalid), 32'd1);
    #2 s0_aresetn = 1'b0;
    #1;
    check_val("rst_mid_rvalid", 32'(s0_rvalid), 32'd0);
    check_val("rst_mid_rdata", s0_rdata, 32'd0);
    check_val("rst_mid_cen", 32'(sram_cen), 32'd0);
    tick(); tick();
    s0_aresetn = 1'b1;
    s0_arvalid = 1'b1; s0_araddr = 32'h20; s0_rready = 1'b1;
    @(negedge clk);
    check_val("rst_rel_no_cen", 32'(sram_cen), 32'd0);
    check_val("rst_rel_rvalid", 32'(s0_rvalid), 32'd0);
    tick();
    s0_arvalid = 1'b0;
    @(negedge clk);
    check_val("rst_rel_cen", 32'(sram_cen), 32'd1);
    check_val("rst_rel_addr", 32'(sram_addr), 32'd8);
    tick(); tick();
    @(negedge clk);
    check_val("rst_rel_rvalid3", 32'(s0_rvalid), 32'd1);
    check_val("rst_rel_rdata", s0_rdata, 32'hCAFEF00D);
    $display("RD addr=00000020 data=%h (after reset)", s0_rdata);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ic_axi_sram_bridge.md
IC_AXI_SRAM_BRIDGE -- requirements
Module: ic_axi_sram_bridge

Interface
- REQ-001 Parameter SRAM_DEPTH_LOG2, default 10, log2 of SRAM depth in 32-bit words.
- REQ-002 Parameter BASE_ADDR, default 32'h0, byte base address; SHALL be aligned to 4<<SRAM_DEPTH_LOG2.
- REQ-003 s0_aclk  in  1  single clock, rising edge.
- REQ-004 s0_aresetn  in  1  reset, asynchronous, active-low.
- REQ-005 s0_awvalid in 1, s0_awready out 1, s0_awaddr in 32, s0_awprot in 3: AXI4-Lite write address channel.
- REQ-006 s0_wvalid in 1, s0_wready out 1, s0_wdata in 32, s0_wstrb in 4: write data channel.
- REQ-007 s0_bvalid out 1, s0_bready in 1, s0_bresp out 2: write response channel.
- REQ-008 s0_arvalid in 1, s0_arready out 1, s0_araddr in 32, s0_arprot in 3: read address channel.
- REQ-009 s0_rvalid out 1, s0_rready in 1, s0_rresp out 2, s0_rdata out 32: read response channel.
- REQ-010 sram_cen out 1 access strobe; sram_wen out 1 write enable; sram_addr out SRAM_DEPTH_LOG2 word address; sram_wdata out 32; sram_wstrb out 4; sram_rdata in 32, valid exactly one cycle after a read strobe.

Function
- REQ-011 AW, W, AR SHALL each have a one-entry buffer; ready = buffer empty; handshake loads the buffer.
- REQ-012 AW and W SHALL be accepted independently, in either order or in the same cycle.
- REQ-013 FSM states: IDLE, RD (SRAM read in flight), RRSP (rvalid held), WRSP (bvalid held).
- REQ-014 In IDLE, a write is eligible when AW and W buffers are both full; a read is eligible when the AR buffer is full.
- REQ-015 Both eligible: a round-robin flag picks the class not served last; flag resets to "write served last" (read wins first).
- REQ-016 Write issue (IDLE): sram_cen=1, sram_wen=1, addr/data/strb from buffers; AW and W buffers clear; next state WRSP, bresp=2'b00.
- REQ-017 Read issue (IDLE): sram_cen=1, sram_wen=0; AR buffer clears; next state RD.
- REQ-018 RD: sram_rdata is registered into s0_rdata; next state RRSP, rresp=2'b00.
- REQ-019 s0_rvalid SHALL be 1 only in RRSP; s0_bvalid only in WRSP; data and resp SHALL stay stable until the handshake; on handshake return to IDLE.
- REQ-020 Latency with ready held high: AR handshake at cycle 0 -> rvalid at cycle 3; AW+W handshake at cycle 0 -> SRAM write at cycle 1, bvalid at cycle 2.
- REQ-021 sram_addr = (addr - BASE_ADDR)[SRAM_DEPTH_LOG2+1:2]; addr[1:0] ignored.
- REQ-022 Outside IDLE, sram_cen SHALL be 0; buffers SHALL keep accepting, so at most one transaction of each channel is pending.
- REQ-023 awprot/arprot SHALL be accepted and ignored.

Reset
- REQ-024 Asynchronous assertion of s0_aresetn SHALL immediately force: FSM to IDLE, buffers empty, all valid outputs 0, sram_cen=0, sram_wen=0, s0_rdata=0, resp=2'b00.
- REQ-025 Reset mid-transaction SHALL drop in-flight responses; no SRAM access SHALL occur in the first cycle after deassertion.

Configuration
- REQ-026 With IC_AXI_SRAM_RANGE_CHECK_EN defined, an address outside [BASE_ADDR, BASE_ADDR + 4<<SRAM_DEPTH_LOG2) SHALL cause no SRAM strobe. A read goes IDLE->RRSP with rdata=0 and rresp=2'b10. A write goes IDLE->WRSP with bresp=2'b10.
- REQ-027 Without the macro, upper address bits SHALL be ignored (address aliases modulo SRAM size) and responses are always 2'b00.

Structure
- REQ-028 Shared package ic_pkg holds the AXI resp constants (OKAY=2'b00, SLVERR=2'b10) and FSM state encodings.
- REQ-029 One sub-module, ic_axi_skid_buf (one-entry valid/ready buffer, parameterised width), instantiated for AW, W and AR.

Verification
- REQ-030 Single write: AW 0x10 and W 0xDEADBEEF/strb 0xF in the same cycle, bready=1 -> SRAM write word 4 at cycle 1, bvalid at cycle 2, bresp 00.
- REQ-031 W one cycle before AW -> wready low until the write issues; the SRAM write occurs once, with the correct data.
- REQ-032 Read back 0x10 with rready held low 5 cycles -> rvalid held, rdata 0xDEADBEEF stable throughout; rvalid at cycle 3 when rready is high.
- REQ-033 Read and write both eligible in the same IDLE cycle after reset -> read issues first, write next; alternation holds over 4 back-to-back pairs.
- REQ-034 With the macro, read 0x1000 (depth 10) -> no sram_cen, rresp 10, rdata 0; without the macro -> aliases to word 0, rresp 00.
- REQ-035 Reset asserted while in RRSP -> rvalid 0 in the same cycle; the next read after release completes normally.
